wts_timer_counter: RTL and testbench



---
 rtl/wts_timer_counter_pkg.sv | 11 +
 rtl/wts_timer_counter_if.sv | 39 +++
 rtl/wts_timer_channel.sv | 61 ++++++
 rtl/wts_timer_counter.sv | 36 +++
 tb/tb_wts_timer_counter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/wts_timer_counter_pkg.sv
// Shared constants and types for the wave table sound dual interval timer.
package wts_timer_counter_pkg;

  localparam int unsigned WTS_TIMER_IDX_BITS = 7;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } wts_timer_state_e;

endpackage

// File: rtl/wts_timer_counter_if.sv
// Register-block <-> timer bundle: per-channel controls in, trigger/address/busy out.
interface wts_timer_counter_if #(
  parameter int unsigned PERIOD_BITS = 16
);
  import wts_timer_counter_pkg::*;

  logic                          tick;
  logic [PERIOD_BITS-1:0]        timer1_period;
  logic                          timer1_start;
  logic                          timer1_stop;
  logic                          timer1_repeat;
  logic                          timer1_trigger;
  logic [WTS_TIMER_IDX_BITS-1:0] timer1_address;
  logic                          timer1_busy;
  logic [PERIOD_BITS-1:0]        timer2_period;
  logic                          timer2_start;
  logic                          timer2_stop;
  logic                          timer2_repeat;
  logic                          timer2_trigger;
  logic [WTS_TIMER_IDX_BITS-1:0] timer2_address;
  logic                          timer2_busy;

  modport master (
    output tick,
    output timer1_period, timer1_start, timer1_stop, timer1_repeat,
    output timer2_period, timer2_start, timer2_stop, timer2_repeat,
    input  timer1_trigger, timer1_address, timer1_busy,
    input  timer2_trigger, timer2_address, timer2_busy
  );

  modport slave (
    input  tick,
    input  timer1_period, timer1_start, timer1_stop, timer1_repeat,
    input  timer2_period, timer2_start, timer2_stop, timer2_repeat,
    output timer1_trigger, timer1_address, timer1_busy,
    output timer2_trigger, timer2_address, timer2_busy
  );

endinterface

// File: rtl/wts_timer_channel.sv
// One timer channel: IDLE/RUN FSM, tick down-counter and 7-bit expiry index.
module wts_timer_channel
  import wts_timer_counter_pkg::*;
#(
  parameter int unsigned PERIOD_BITS = 16
) (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic                          tick,
  input  logic [PERIOD_BITS-1:0]        period,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          repeat_mode,
  output logic                          trigger,
  output logic [WTS_TIMER_IDX_BITS-1:0] address,
  output logic                          busy
);

  wts_timer_state_e              state;
  logic [PERIOD_BITS-1:0]        count;
  logic [WTS_TIMER_IDX_BITS-1:0] index;
  logic                          start_ok;

  // A start with a zero period is treated as absent, so stop/tick still apply.
  assign start_ok = start && (period != '0);
  assign busy     = (state == RUN);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= IDLE;
      count   <= '0;
      index   <= '0;
      trigger <= 1'b0;
      address <= '0;
    end else begin
      trigger <= 1'b0;
      if (start_ok) begin
        count <= period;
        index <= '0;
        state <= RUN;
      end else if (stop) begin
        state <= IDLE;
      end else if (state == RUN && tick) begin
        if (count != PERIOD_BITS'(1)) begin
          count <= count - 1'b1;
        end else begin
          trigger <= 1'b1;
          address <= index;
          index   <= index + 1'b1;
          if (repeat_mode) begin
            count <= period;
            if (period == '0) state <= IDLE;
          end else begin
            state <= IDLE;
          end
        end
      end
    end
  end

endmodule

// File: rtl/wts_timer_counter.sv
// Dual programmable interval timer feeding the interrupt-status latch; wiring only.
module wts_timer_counter #(
  parameter int unsigned PERIOD_BITS = 16
) (
  input logic                clk,
  input logic                nreset,
  wts_timer_counter_if.slave bus
);

  wts_timer_channel #(.PERIOD_BITS(PERIOD_BITS)) u_timer1 (
    .clk         (clk),
    .nreset      (nreset),
    .tick        (bus.tick),
    .period      (bus.timer1_period),
    .start       (bus.timer1_start),
    .stop        (bus.timer1_stop),
    .repeat_mode (bus.timer1_repeat),
    .trigger     (bus.timer1_trigger),
    .address     (bus.timer1_address),
    .busy        (bus.timer1_busy)
  );

  wts_timer_channel #(.PERIOD_BITS(PERIOD_BITS)) u_timer2 (
    .clk         (clk),
    .nreset      (nreset),
    .tick        (bus.tick),
    .period      (bus.timer2_period),
    .start       (bus.timer2_start),
    .stop        (bus.timer2_stop),
    .repeat_mode (bus.timer2_repeat),
    .trigger     (bus.timer2_trigger),
    .address     (bus.timer2_address),
    .busy        (bus.timer2_busy)
  );

endmodule

// File: tb/tb_wts_timer_counter.sv
// Directed bench for wts_timer_counter with hand-computed expected values.
module tb_wts_timer_counter;

  localparam int unsigned PERIOD_BITS = 16;

  logic clk;
  logic nreset;
  int unsigned checks;
  int unsigned errors;

  wts_timer_counter_if #(.PERIOD_BITS(PERIOD_BITS)) bus ();

  wts_timer_counter #(.PERIOD_BITS(PERIOD_BITS)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs changed after this are sampled on the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_trig1"}, 32'(bus.timer1_trigger), 0);
    check({tag, "_trig2"}, 32'(bus.timer2_trigger), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nreset = 1'b0;
    bus.tick = 1'b0;
    bus.timer1_period = '0; bus.timer1_start = 1'b0; bus.timer1_stop = 1'b0; bus.timer1_repeat = 1'b0;
    bus.timer2_period = '0; bus.timer2_start = 1'b0; bus.timer2_stop = 1'b0; bus.timer2_repeat = 1'b0;

    // Reset values, then idle with tick every cycle
    step(); step();
    check("rst_trig1", 32'(bus.timer1_trigger), 0);
    check("rst_addr1", 32'(bus.timer1_address), 0);
    check("rst_busy1", 32'(bus.timer1_busy), 0);
    check("rst_trig2", 32'(bus.timer2_trigger), 0);
    check("rst_addr2", 32'(bus.timer2_address), 0);
    check("rst_busy2", 32'(bus.timer2_busy), 0);
    nreset = 1'b1;
    bus.tick = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_quiet("idle");
      check("idle_busy1", 32'(bus.timer1_busy), 0);
      check("idle_busy2", 32'(bus.timer2_busy), 0);
    end

    // Channel 1 one-shot, period 3
    bus.timer1_period = 16'd3; bus.timer1_repeat = 1'b0; bus.timer1_start = 1'b1;
    step();
    bus.timer1_start = 1'b0;
    check("os_busy_rise", 32'(bus.timer1_busy), 1);
    check("os_trig_e1", 32'(bus.timer1_trigger), 0);
    step(); check("os_trig_e2", 32'(bus.timer1_trigger), 0);
    step(); check("os_trig_e3", 32'(bus.timer1_trigger), 0);
    step();
    check("os_trig", 32'(bus.timer1_trigger), 1);
    check("os_addr", 32'(bus.timer1_address), 0);
    check("os_busy_fall", 32'(bus.timer1_busy), 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("os_after", 32'(bus.timer1_trigger), 0);
    end

    // Channel 2 auto-reload, period 2, 130 expiries with index wrap
    bus.timer2_period = 16'd2; bus.timer2_repeat = 1'b1; bus.timer2_start = 1'b1;
    step();
    bus.timer2_start = 1'b0;
    check("rp_busy", 32'(bus.timer2_busy), 1);
    for (int i = 0; i < 130; i++) begin
      step();
      check("rp_gap", 32'(bus.timer2_trigger), 0);
      step();
      check("rp_trig", 32'(bus.timer2_trigger), 1);
      check("rp_addr", 32'(bus.timer2_address), 32'(i % 128));
      check("rp_busy_hold", 32'(bus.timer2_busy), 1);
    end
    bus.timer2_stop = 1'b1;
    step();
    bus.timer2_stop = 1'b0;
    check("rp_stop_busy", 32'(bus.timer2_busy), 0);

    // Channel 1 repeat, period 3: stop on the expiry cycle, then start+stop together
    bus.timer1_period = 16'd3; bus.timer1_repeat = 1'b1; bus.timer1_start = 1'b1;
    step();
    bus.timer1_start = 1'b0;
    step(); step(); step();
    check("sx_trig0", 32'(bus.timer1_trigger), 1);
    check("sx_addr0", 32'(bus.timer1_address), 0);
    step(); step();
    bus.timer1_stop = 1'b1;
    step();
    bus.timer1_stop = 1'b0;
    check("sx_stop_trig", 32'(bus.timer1_trigger), 0);
    check("sx_stop_busy", 32'(bus.timer1_busy), 0);
    check("sx_stop_addr", 32'(bus.timer1_address), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("sx_halted", 32'(bus.timer1_trigger), 0);
    end
    bus.timer1_start = 1'b1; bus.timer1_stop = 1'b1;
    step();
    bus.timer1_start = 1'b0; bus.timer1_stop = 1'b0;
    check("ss_busy", 32'(bus.timer1_busy), 1);
    step(); check("ss_gap1", 32'(bus.timer1_trigger), 0);
    step(); check("ss_gap2", 32'(bus.timer1_trigger), 0);
    step();
    check("ss_trig", 32'(bus.timer1_trigger), 1);
    check("ss_addr", 32'(bus.timer1_address), 0);
    bus.timer1_stop = 1'b1;
    step();
    bus.timer1_stop = 1'b0;

    // Zero-period start ignored; period change mid-run applies at the reload
    bus.timer1_period = '0; bus.timer1_start = 1'b1;
    step();
    bus.timer1_start = 1'b0;
    check("p0_busy_a", 32'(bus.timer1_busy), 0);
    step();
    check("p0_busy_b", 32'(bus.timer1_busy), 0);
    bus.timer1_period = 16'd4; bus.timer1_repeat = 1'b1; bus.timer1_start = 1'b1;
    step();
    bus.timer1_start = 1'b0;
    check("pc_busy", 32'(bus.timer1_busy), 1);
    step(); check("pc_e2", 32'(bus.timer1_trigger), 0);
    bus.timer1_period = 16'd2;
    step(); check("pc_e3", 32'(bus.timer1_trigger), 0);
    step(); check("pc_e4", 32'(bus.timer1_trigger), 0);
    step();
    check("pc_trig4", 32'(bus.timer1_trigger), 1);
    check("pc_addr0", 32'(bus.timer1_address), 0);
    step(); check("pc_e6", 32'(bus.timer1_trigger), 0);
    step();
    check("pc_trig2", 32'(bus.timer1_trigger), 1);
    check("pc_addr1", 32'(bus.timer1_address), 1);
    bus.timer1_stop = 1'b1;
    step();
    bus.timer1_stop = 1'b0;

    // Both channels period 1, tick every 5 cycles, then reset mid-run
    bus.tick = 1'b0;
    bus.timer1_period = 16'd1; bus.timer1_repeat = 1'b1; bus.timer1_start = 1'b1;
    bus.timer2_period = 16'd1; bus.timer2_repeat = 1'b1; bus.timer2_start = 1'b1;
    step();
    bus.timer1_start = 1'b0; bus.timer2_start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) begin
        step();
        check_quiet("co_gap");
      end
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
      check("co_trig1", 32'(bus.timer1_trigger), 1);
      check("co_trig2", 32'(bus.timer2_trigger), 1);
      check("co_addr1", 32'(bus.timer1_address), 32'(r));
      check("co_addr2", 32'(bus.timer2_address), 32'(r));
    end
    step(); step();
    #3 nreset = 1'b0;
    #1;
    check("ar_busy1", 32'(bus.timer1_busy), 0);
    check("ar_busy2", 32'(bus.timer2_busy), 0);
    check("ar_addr1", 32'(bus.timer1_address), 0);
    check("ar_addr2", 32'(bus.timer2_address), 0);
    check_quiet("ar");
    #2 nreset = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 5; k++) begin
        bus.tick = (k == 4);
        step();
        check_quiet("post_rst");
        check("post_rst_busy1", 32'(bus.timer1_busy), 0);
        check("post_rst_busy2", 32'(bus.timer2_busy), 0);
      end
    end
    bus.tick = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
